// File: rtl/timer_compare_irq_pkg.sv
// rtl/timer_compare_irq_pkg.sv - shared timer constants for the compare/interrupt stage
package timer_compare_irq_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = WORD_W / 8;

    localparam logic [63:0] CMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int TIER_INT_EN_BIT = 0;
    localparam int TISR_INT_ST_BIT = 0;

endpackage

// File: rtl/timer_compare_irq_if.sv
// rtl/timer_compare_irq_if.sv - register-write bus from the APB decoder into the compare stage
interface timer_compare_irq_if;
    import timer_compare_irq_pkg::*;

    logic [WORD_W-1:0] wdata_cmp;
    logic [STRB_W-1:0] pstrb;
    logic              tcmp0_wr_sel;
    logic              tcmp1_wr_sel;
    logic              tier_wr_sel;
    logic              tisr_wr_sel;

    modport master (
        output wdata_cmp, pstrb, tcmp0_wr_sel, tcmp1_wr_sel, tier_wr_sel, tisr_wr_sel
    );

    modport slave (
        input wdata_cmp, pstrb, tcmp0_wr_sel, tcmp1_wr_sel, tier_wr_sel, tisr_wr_sel
    );

endinterface

// File: rtl/timer_compare_irq_byte_strobe_reg32.sv
// rtl/timer_compare_irq_byte_strobe_reg32.sv - 32-bit register with per-byte strobed load
module byte_strobe_reg32
    import timer_compare_irq_pkg::*;
#(
    parameter logic [WORD_W-1:0] RST_VAL = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [STRB_W-1:0] strb,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (strb[i]) begin
                    data_d[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/timer_compare_irq.sv
// rtl/timer_compare_irq.sv - 64-bit compare register, match edge detect and sticky W1C timer interrupt
module timer_compare_irq
    import timer_compare_irq_pkg::*;
#(
    parameter logic [63:0] CMP_RST = CMP_RST_DEFAULT
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [63:0]          cnt,
    timer_compare_irq_if.slave   bus,
    output logic [63:0]          cmp,
    output logic                 int_en,
    output logic                 int_st,
    output logic                 tim_int
);

    logic match;
    logic match_event;
    logic st_clear;

    logic match_q,  match_d;
    logic int_en_q, int_en_d;
    logic int_st_q, int_st_d;

    byte_strobe_reg32 #(.RST_VAL(CMP_RST[31:0])) u_cmp_lo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .wr_en (bus.tcmp0_wr_sel),
        .strb  (bus.pstrb),
        .wdata (bus.wdata_cmp),
        .q     (cmp[31:0])
    );

    byte_strobe_reg32 #(.RST_VAL(CMP_RST[63:32])) u_cmp_hi (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .wr_en (bus.tcmp1_wr_sel),
        .strb  (bus.pstrb),
        .wdata (bus.wdata_cmp),
        .q     (cmp[63:32])
    );

    // A standing match fires once; clearing status while it persists does not re-arm it.
    assign match       = (cnt == cmp);
    assign match_event = match & ~match_q;
    assign st_clear    = bus.tisr_wr_sel & bus.pstrb[0] & bus.wdata_cmp[TISR_INT_ST_BIT];

    always_comb begin
        match_d  = match;
        int_en_d = int_en_q;
        int_st_d = int_st_q;
        if (bus.tier_wr_sel && bus.pstrb[0]) begin
            int_en_d = bus.wdata_cmp[TIER_INT_EN_BIT];
        end
        if (match_event) begin
            int_st_d = 1'b1;
        end else if (st_clear) begin
            int_st_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            match_q  <= 1'b0;
            int_en_q <= 1'b0;
            int_st_q <= 1'b0;
        end else begin
            match_q  <= match_d;
            int_en_q <= int_en_d;
            int_st_q <= int_st_d;
        end
    end

    assign int_en  = int_en_q;
    assign int_st  = int_st_q;
    assign tim_int = int_en_q & int_st_q;

endmodule

// File: doc/timer_compare_irq.md
# timer_compare_irq

Compare-and-interrupt stage directly downstream of the 64-bit timer counter. It holds a byte-writable 64-bit compare value and detects the rising edge of `cnt == cmp`. It keeps a sticky interrupt status (write-1-to-clear) and drives the masked timer interrupt to the system. Register-select strobes come from the same APB register decoder that drives the counter's data-register selects.

## Interface
Parameters:
- `CMP_RST` — default 64'hFFFF_FFFF_FFFF_FFFF — reset value of the compare register

Ports:
- `sys_clk` in 1 — single clock; all state on rising edge
- `sys_rst` in 1 — reset, asynchronous and active-high
- `cnt` in 64 — live counter value from the counter stage
- `wdata_cmp` in 32 — APB write data
- `pstrb` in 4 — APB byte strobes; bit i enables byte i of `wdata_cmp`
- `tcmp0_wr_sel` in 1 — write strobe, compare low word `cmp[31:0]`
- `tcmp1_wr_sel` in 1 — write strobe, compare high word `cmp[63:32]`
- `tier_wr_sel` in 1 — write strobe, interrupt enable (bit 0)
- `tisr_wr_sel` in 1 — write strobe, interrupt status (bit 0, W1C)
- `cmp` out 64 — compare register, for readback
- `int_en` out 1 — interrupt enable register
- `int_st` out 1 — sticky interrupt status
- `tim_int` out 1 — interrupt output, `int_en & int_st`

## Operation
- Reset values: `cmp = CMP_RST`, `int_en = 0`, `int_st = 0`, internal `match_q = 0`, `tim_int = 0`.
- Compare write:
  - `tcmp0_wr_sel` updates `cmp[8i+7:8i]` from `wdata_cmp[8i+7:8i]` for each set `pstrb[i]`.
  - `tcmp1_wr_sel` does the same on `cmp[32+8i+7:32+8i]`.
  - Bytes with their strobe clear hold their value.
- `tier_wr_sel` with `pstrb[0]=1` loads `int_en <= wdata_cmp[0]`. With `pstrb[0]=0` there is no change.
- Match:
  - `match = (cnt == cmp)` is a combinational full 64-bit equality.
  - `match_q <= match` every cycle.
  - The event fires when `match & ~match_q`.
- Status:
  - An event sets `int_st`.
  - `tisr_wr_sel & pstrb[0] & wdata_cmp[0]` clears `int_st`.
  - Writing 0 to the status bit has no effect.
  - Event and clear in the same cycle: the set wins and `int_st` stays 1.
- A match that persists (counter halted at `cmp`) produces only one event. Clearing status while the match persists does not re-set it.
- Re-writing `cmp` so that it equals the current `cnt` creates a new rising edge, provided `match_q` was 0.
- Counter wrap (all-ones to 0) needs no special handling. `cmp = 0` matches on wrap or on counter reset-by-write.
- Decoder guarantees at most one `*_wr_sel` per cycle. If several are asserted, each applies independently to its own register.
- `int_en` masks only the output. `int_st` still sets while `int_en = 0`, and asserting `int_en` later raises `tim_int` immediately.

## Timing
- All outputs are register-driven. `tim_int` is the AND of two flops, with no combinational path from inputs.
- `cnt` equals `cmp` during cycle N → `match_q = 1` and `int_st = 1` after edge N+1. `tim_int` is high from cycle N+1 when `int_en = 1`.
- A `cmp` write at edge W: the new value is visible on `cmp` in cycle W+1, and the match against it takes effect from cycle W+1.
- A W1C write at edge C: `int_st = 0` from cycle C+1, unless an event occurs at the same edge.
- Asserting `sys_rst` at any time immediately forces all reset values, including mid-event. After release, `match_q = 0`, so a standing match at release produces an event on the first clock.

## Structure
- Shared timer package: `CMP_RST` default, register-bit index constants (`TIER_INT_EN_BIT = 0`, `TISR_INT_ST_BIT = 0`).
- One natural sub-module: `byte_strobe_reg32`, a 32-bit register with per-byte strobe load, instantiated twice for the compare words. It is reusable by the counter stage.
- Edge detect and status logic stay in the top module.

## Test plan
- Reset: assert `sys_rst` mid-run → `cmp = 64'hFFFF_FFFF_FFFF_FFFF`, `int_en = 0`, `int_st = 0`, `tim_int = 0` immediately, with no clock needed.
- Partial write: `tcmp0_wr_sel`, `pstrb = 4'b0101`, `wdata = 32'hAABBCCDD` on reset `cmp` → `cmp[31:0] = 32'hFFBBFFDD`, high word unchanged.
- Match and interrupt:
  - Setup: `cmp = 64'h0000_0001_0000_0010`, `int_en = 1`, `cnt` stepping through `64'h0000_0001_0000_0010`.
  - Required: `int_st` and `tim_int` go high exactly one cycle after the match cycle.
- Held match: `cnt` held equal to `cmp` for 10 cycles, W1C at cycle 3 → `int_st` clears and stays 0 for the remaining cycles.
- Set-vs-clear collision: W1C in the same cycle as a new rising match → `int_st` remains 1.
- Masking:
  - Match with `int_en = 0` → `int_st = 1`, `tim_int = 0`.
  - Then write `tier = 1` → `tim_int = 1` the next cycle.
  - Write `pstrb = 0` to `tier` → no change.
